gate_fitness_eval: RTL

- Sequential, parametrised evaluator for evolved gate netlists: the next generation of our fixed combinational candidate circuits.
- Holds a programmable chromosome of N_GATES two-input gates.
- Sweeps all 2^N_IN input vectors, one gate per cycle, and compares the selected output net against a target truth table.
- Returns a match-count fitness to the GA controller, replacing per-candidate hand-written netlists.

---
 rtl/gate_fitness_eval.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/gate_fitness_eval.sv
// Sequential fitness evaluator for a chromosome of two-input gates; sweeps all input vectors.
// Latency: done pulses 2^N_IN*(N_GATES+1)+1 cycles after start (early-abort build may finish sooner).
// No backpressure: start and gene writes are ignored while busy; optional feature macro EARLY_ABORT_EN.
module gate_fitness_eval #(
  parameter int N_IN = 4,
  parameter int N_GATES = 14,
  localparam int P = 2*N_IN + N_GATES,
  localparam int SRC_W = $clog2(P),
  localparam int GENE_W = 3 + 2*SRC_W,
  localparam int AW = (N_GATES > 1) ? $clog2(N_GATES) : 1,
  localparam int NV = 1 << N_IN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gene_we,
  input  logic [AW-1:0]     gene_addr,
  input  logic [GENE_W-1:0] gene_data,
  input  logic [SRC_W-1:0]  out_sel,
  input  logic [NV-1:0]     target,
  input  logic              start,
`ifdef EARLY_ABORT_EN
  input  logic [N_IN:0]     abort_limit,
  output logic              aborted,
`endif
  output logic              busy,
  output logic              done,
  output logic [N_IN:0]     fitness,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, EVAL, CMP, DONE} state_t;

  state_t              state, state_nx;
  logic [GENE_W-1:0]   genes [N_GATES];
  logic [N_GATES-1:0]  gate_val;
  logic [AW-1:0]       g;
  logic [N_IN-1:0]     v;
  logic [SRC_W-1:0]    sel_q;
  logic [NV-1:0]       tgt_q;
  logic [N_IN:0]       score, miss;
  logic [N_IN:0]       score_nx, miss_nx;
  logic [P-1:0]        pool;
  logic [GENE_W-1:0]   cur;
  logic [2:0]          op;
  logic [SRC_W-1:0]    sa, sb;
  logic                a_ok, b_bad, a_val, b_val, gate_out;
  logic                out_ok, out_bit, match;
  logic                last_g, last_v, abort_hit, finish;
`ifdef EARLY_ABORT_EN
  logic [N_IN:0]       lim_q;
`endif

  // A source is legal if it is a primary (or inverted) input or a strictly earlier gate.
  function automatic logic src_legal(input logic [SRC_W-1:0] s, input int lim);
    return int'(s) < 2*N_IN + lim;
  endfunction

  assign pool = {gate_val, ~v, v};

  // Evaluate the current gate and score the selected output net for the current vector.
  always_comb begin
    cur      = genes[g];
    op       = cur[GENE_W-1 -: 3];
    sa       = cur[2*SRC_W-1 -: SRC_W];
    sb       = cur[SRC_W-1:0];
    a_ok     = src_legal(sa, int'(g));
    b_bad    = (op < 3'd6) && !src_legal(sb, int'(g));
    a_val    = a_ok ? pool[sa] : 1'b0;
    b_val    = (src_legal(sb, int'(g))) ? pool[sb] : 1'b0;
    gate_out = 1'b0;
    case (op)
      3'd0:    gate_out = a_val & b_val;
      3'd1:    gate_out = a_val | b_val;
      3'd2:    gate_out = ~(a_val & b_val);
      3'd3:    gate_out = ~(a_val | b_val);
      3'd4:    gate_out = a_val ^ b_val;
      3'd5:    gate_out = ~(a_val ^ b_val);
      3'd6:    gate_out = a_val;
      default: gate_out = ~a_val;
    endcase
    out_ok    = src_legal(sel_q, N_GATES);
    out_bit   = out_ok ? pool[sel_q] : 1'b0;
    match     = (out_bit == tgt_q[v]);
    score_nx  = score + {{N_IN{1'b0}}, match};
    miss_nx   = miss + {{N_IN{1'b0}}, ~match};
    last_g    = (g == AW'(N_GATES-1));
    last_v    = (v == N_IN'(NV-1));
`ifdef EARLY_ABORT_EN
    abort_hit = (miss_nx > lim_q);
`else
    abort_hit = 1'b0;
`endif
    finish    = last_v || abort_hit;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = EVAL;
      EVAL: begin
        busy = 1'b1;
        if (last_g) state_nx = CMP;
      end
      CMP: begin
        busy     = 1'b1;
        state_nx = finish ? DONE : EVAL;
      end
      default: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

  // Chromosome storage, sweep counters, scoring and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_GATES; i++) genes[i] <= '0;
      gate_val <= '0;
      g        <= '0;
      v        <= '0;
      sel_q    <= '0;
      tgt_q    <= '0;
      score    <= '0;
      miss     <= '0;
      fitness  <= '0;
      err      <= 1'b0;
`ifdef EARLY_ABORT_EN
      lim_q    <= '0;
      aborted  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gene_we && int'(gene_addr) < N_GATES) genes[gene_addr] <= gene_data;
          if (start) begin
            sel_q <= out_sel;
            tgt_q <= target;
            v     <= '0;
            g     <= '0;
            score <= '0;
            miss  <= '0;
            err   <= 1'b0;
`ifdef EARLY_ABORT_EN
            lim_q   <= abort_limit;
            aborted <= 1'b0;
`endif
          end
        end
        EVAL: begin
          gate_val[g] <= gate_out;
          if (!a_ok || b_bad) err <= 1'b1;
          if (!last_g) g <= g + AW'(1);
        end
        CMP: begin
          score <= score_nx;
          miss  <= miss_nx;
          if (!out_ok) err <= 1'b1;
          if (finish) begin
            fitness <= score_nx;
`ifdef EARLY_ABORT_EN
            aborted <= abort_hit;
`endif
          end else begin
            v <= v + N_IN'(1);
            g <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
